tone_meter: RTL and testbench
=============================

# tone_meter

Receive-side decoder for the 1-bit gated square-wave audio stream produced by the tone/noise generators. It measures the stream and reports, once per cycle of the waveform:
- the full period in clock cycles (pitch), and
- the high time in clock cycles (gated duty, i.e. volume).

It sits on the audio line next to a generator and feeds self-test and visualisation logic, which read `o_Period`/`o_High` on each `o_Valid` pulse.

## Interface
Parameters:
- `WIDTH`, 16 — width of the period and high-time counters and outputs.
- `TIMEOUT`, 40000 — cycles without a rising edge before the input is declared silent. Legal range 2 to 2^WIDTH-1.

Ports:
- `i_Clk` in 1 — the single clock. All logic runs on its rising edge.
- `i_Reset_n` in 1 — reset, asynchronous and active-low. Release is synchronous to `i_Clk`.
- `i_In` in 1 — audio bit, asynchronous to `i_Clk`.
- `o_Period` out WIDTH — cycles between the last two rising edges of `i_In`.
- `o_High` out WIDTH — cycles `i_In` was high within that period.
- `o_Valid` out 1 — one-cycle pulse when `o_Period`/`o_High` update.
- `o_Active` out 1 — high while a periodic signal is being tracked.
- `o_Stuck` out 1 — high while the input has been held high for `TIMEOUT` cycles.

## Operation
- **Synchronizer:** 3-flop chain `s1`→`s2`→`s3`.
  - `rise` = `s2 & ~s3`
  - `fall` = `~s2 & s3`
- **Counters:** `cnt` and `hcnt`, each WIDTH bits, saturating at 2^WIDTH-1 (no wrap).
- **States:** IDLE, HIGH, LOW.
- **IDLE** (reset state):
  - `cnt`/`hcnt` held at 0.
  - On `rise`: `cnt` and `hcnt` load 1, go to HIGH. No measurement is emitted.
- **HIGH:**
  - Each cycle: `cnt` += 1; `hcnt` += 1 while `s2` is 1.
  - On `fall`: go to LOW; `hcnt` freezes.
  - If `cnt` reaches `TIMEOUT`: go to IDLE, set `o_Stuck`=1, clear `o_Active`.
- **LOW:**
  - Each cycle: `cnt` += 1.
  - On `rise`:
    - register `o_Period` <= `cnt` and `o_High` <= `hcnt`;
    - pulse `o_Valid`, set `o_Active`=1;
    - reload `cnt`=1, `hcnt`=1, go to HIGH.
  - If `cnt` reaches `TIMEOUT`: go to IDLE, clear `o_Active`. `o_Stuck` stays 0.
- **Measurement outputs:** `o_Period`/`o_High` hold their last value until the next `o_Valid`. A timeout does not change them.
- **`o_Stuck`:** clears on the first `fall` after it was set.
- **Simultaneous events:**
  - `rise` on the cycle `cnt` reaches `TIMEOUT` in LOW: the rise wins. The measurement is emitted with `o_Period`=`TIMEOUT` and the block stays Active.
  - `rise` and `fall` cannot coincide, because they are derived from the same two flops.
- **Reset mid-operation:** all state returns to reset values immediately. Partial measurements are discarded and no `o_Valid` is issued.
- **Reset values:** `o_Period`=0, `o_High`=0, `o_Valid`=0, `o_Active`=0, `o_Stuck`=0, `s1`..`s3`=0, state IDLE.

## Timing
- **Input latency:** `i_In` sampled high at clock edge k → `rise` true during the cycle after edge k+1.
- **Output latency:** `o_Valid`, `o_Period`, `o_High` and `o_Active` update at edge k+2, i.e. 3 edges after the first sample.
- **`o_Valid` width:** exactly one cycle per rising edge of `i_In`, except the first rise after IDLE, which produces no pulse.
- **`o_Period` definition:** the number of clock edges between consecutive detected rises. A square wave of N cycles per period gives `o_Period`=N.
- **`o_High` definition:** the number of cycles `s2` was 1 from the rise to the fall, inclusive of the rise cycle.
- **Pulse spacing:** minimum 2 cycles between `o_Valid` pulses (input high 1, low 1). Shorter input features are not guaranteed to be resolved.
- **Timeout and stuck flags:**
  - Silence is flagged with `o_Active`=0 on the edge where `cnt`==`TIMEOUT` is reached.
  - `o_Stuck` rises on that same edge.

## Test plan
- **Steady tone:** reset, then `i_In` repeats 5 cycles high / 11 low.
  - First `o_Valid` at the second rise.
  - Every pulse after that: `o_Period`=16, `o_High`=5, `o_Active`=1, pulses exactly 16 cycles apart.
- **Latency check:** `i_In` rises 1 ns before edge k (second rise).
  - `o_Valid`=1 only in the cycle after edge k+2.
  - `o_Valid`=0 before that cycle and after it.
- **Silence:** `TIMEOUT`=100; tone (period 16) then `i_In` held low.
  - `o_Active` falls exactly 100 cycles after the last rise; `o_Stuck`=0.
  - Outputs hold 16/5.
  - The next tone needs two rises before `o_Valid`.
- **Stuck high:** `TIMEOUT`=100; `i_In` held high after a rise.
  - `o_Stuck`=1 and `o_Active`=0 after 100 cycles.
  - The first low on `i_In` clears `o_Stuck` within 3 cycles.
- **Boundary:**
  - Period exactly 100 with `TIMEOUT`=100 → valid measurement `o_Period`=100, `o_Active` stays 1.
  - Period 2 (1 high / 1 low) → `o_Period`=2, `o_High`=1.
- **Reset mid-period:** assert `i_Reset_n`=0 during the high phase of tone 16/5.
  - All outputs read 0 immediately (asynchronous).
  - After release, the first valid measurement is 16/5 at the second subsequent rise.

Source files
------------

// File: rtl/tone_meter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tone_meter : measures period and high time of a 1-bit gated square wave
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tone_meter #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 40000
) (
   input  logic             i_Clk,
   input  logic             i_Reset_n,
   input  logic             i_In,
   output logic [WIDTH-1:0] o_Period,
   output logic [WIDTH-1:0] o_High,
   output logic             o_Valid,
   output logic             o_Active,
   output logic             o_Stuck
);

   localparam logic [WIDTH-1:0] c_MAX     = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_TIMEOUT = WIDTH'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_s1, r_s2, r_s3;
   logic [WIDTH-1:0] r_cnt, r_hcnt;
   logic             w_rise, w_fall, w_timeout;
   logic [WIDTH-1:0] w_cnt_inc, w_hcnt_inc;

   assign w_rise     = r_s2 & ~r_s3;
   assign w_fall     = ~r_s2 & r_s3;
   assign w_timeout  = (r_cnt == c_TIMEOUT);
   assign w_cnt_inc  = (r_cnt  == c_MAX) ? r_cnt  : r_cnt  + c_ONE;
   assign w_hcnt_inc = (r_hcnt == c_MAX) ? r_hcnt : r_hcnt + c_ONE;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_s3     <= 1'b0;
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_hcnt   <= '0;
         o_Period <= '0;
         o_High   <= '0;
         o_Valid  <= 1'b0;
         o_Active <= 1'b0;
         o_Stuck  <= 1'b0;
      end else begin
         r_s1    <= i_In;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         o_Valid <= 1'b0;
         if (w_fall)
            o_Stuck <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_cnt  <= '0;
               r_hcnt <= '0;
               // First edge after silence only starts timing; nothing to report yet
               if (w_rise) begin
                  r_cnt   <= c_ONE;
                  r_hcnt  <= c_ONE;
                  r_state <= ST_HIGH;
               end
            end

            ST_HIGH: begin
               r_cnt <= w_cnt_inc;
               if (r_s2)
                  r_hcnt <= w_hcnt_inc;
               if (w_fall) begin
                  r_state <= ST_LOW;
               end else if (w_timeout) begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_hcnt   <= '0;
                  o_Stuck  <= 1'b1;
                  o_Active <= 1'b0;
               end
            end

            ST_LOW: begin
               r_cnt <= w_cnt_inc;
               // A rise landing on the timeout cycle still counts as a valid period
               if (w_rise) begin
                  o_Period <= r_cnt;
                  o_High   <= r_hcnt;
                  o_Valid  <= 1'b1;
                  o_Active <= 1'b1;
                  r_cnt    <= c_ONE;
                  r_hcnt   <= c_ONE;
                  r_state  <= ST_HIGH;
               end else if (w_timeout) begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_hcnt   <= '0;
                  o_Active <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_hcnt  <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tone_meter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_tone_meter : directed self-checking bench for tone_meter (TIMEOUT = 100)
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tb_tone_meter;

   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 100;

   logic             clk;
   logic             rst_n;
   logic             in_bit;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high;
   logic             valid;
   logic             active;
   logic             stuck;

   int checks = 0;
   int errors = 0;

   tone_meter #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .i_In      (in_bit),
      .o_Period  (period),
      .o_High    (high),
      .o_Valid   (valid),
      .o_Active  (active),
      .o_Stuck   (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one input bit; return at the negedge after the edge that samples it.
   task automatic step(input logic v);
      in_bit = v;
      @(negedge clk);
   endtask

   // Square wave h high / l low for n periods, starting with a rise at idx 0.
   // Rise at idx i is reported at idx i+2; a fresh start skips the first rise.
   task automatic tone(input int h, input int l, input int n, input bit fresh,
                       input int ep, input int eh);
      int  p;
      bit  ev;
      p = h + l;
      for (int idx = 0; idx < p * n; idx++) begin
         step((idx % p) < h);
         ev = (idx >= 2) && (((idx - 2) % p) == 0) && (((idx - 2) / p) >= (fresh ? 1 : 0));
         check("tone_valid", 32'(valid), 32'(ev));
         if (ev) begin
            check("tone_period", 32'(period), 32'(ep));
            check("tone_high",   32'(high),   32'(eh));
            check("tone_active", 32'(active), 32'd1);
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      in_bit = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_period", 32'(period), 32'd0);
      check("rst_high",   32'(high),   32'd0);
      check("rst_valid",  32'(valid),  32'd0);
      check("rst_active", 32'(active), 32'd0);
      check("rst_stuck",  32'(stuck),  32'd0);
      rst_n = 1'b1;
      repeat (3) step(1'b0);

      // Steady tone 5 high / 11 low
      tone(5, 11, 4, 1'b1, 16, 5);

      // Silence: last rise at idx 48, reported at 50, timeout 100 edges later
      for (int idx = 64; idx <= 160; idx++) begin
         step(1'b0);
         check("sil_active", 32'(active), 32'(idx < 150));
         check("sil_stuck",  32'(stuck),  32'd0);
         check("sil_valid",  32'(valid),  32'd0);
      end
      check("sil_hold_period", 32'(period), 32'd16);
      check("sil_hold_high",   32'(high),   32'd5);

      // Restart needs two rises
      tone(5, 11, 2, 1'b1, 16, 5);

      // Latency: rise applied 1 ns before edge k
      #4 in_bit = 1'b1;
      @(negedge clk);
      check("lat_k0", 32'(valid), 32'd0);
      @(negedge clk);
      check("lat_k1", 32'(valid), 32'd0);
      @(negedge clk);
      check("lat_k2",        32'(valid),  32'd1);
      check("lat_k2_period", 32'(period), 32'd16);
      check("lat_k2_high",   32'(high),   32'd5);
      @(negedge clk);
      check("lat_k3", 32'(valid), 32'd0);
      @(negedge clk);
      repeat (120) step(1'b0);
      check("lat_idle_active", 32'(active), 32'd0);

      // Stuck high: rise acted at idx 2, timeout at idx 102
      for (int idx = 0; idx <= 110; idx++) begin
         step(1'b1);
         check("stk_stuck",  32'(stuck),  32'(idx >= 102));
         check("stk_active", 32'(active), 32'd0);
      end
      step(1'b0);
      check("stk_clr0", 32'(stuck), 32'd1);
      step(1'b0);
      check("stk_clr1", 32'(stuck), 32'd1);
      step(1'b0);
      check("stk_clr2", 32'(stuck), 32'd0);
      repeat (5) step(1'b0);

      // Period equal to TIMEOUT: rise wins over timeout
      tone(10, 90, 3, 1'b1, 100, 10);
      check("bnd_active", 32'(active), 32'd1);
      repeat (120) step(1'b0);
      check("bnd_idle_active", 32'(active), 32'd0);

      // Shortest resolvable period
      tone(1, 1, 8, 1'b1, 2, 1);

      // Asynchronous reset during a high phase
      repeat (3) step(1'b1);
      check("pre_rst_active", 32'(active), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_period", 32'(period), 32'd0);
      check("mid_rst_high",   32'(high),   32'd0);
      check("mid_rst_valid",  32'(valid),  32'd0);
      check("mid_rst_active", 32'(active), 32'd0);
      check("mid_rst_stuck",  32'(stuck),  32'd0);
      in_bit = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tone(5, 11, 3, 1'b1, 16, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
